// File: rtl/mbus_ext_int_ctrl_pkg.sv
// Shared constants for the MBus external-interrupt controller:
// FSM state encodings, watchdog counter width and a modulo helper.
package mbus_ext_int_ctrl_pkg;

  localparam logic [2:0] MBUS_EIC_IDLE     = 3'd0;
  localparam logic [2:0] MBUS_EIC_WAIT_BUS = 3'd1;
  localparam logic [2:0] MBUS_EIC_ASSERT   = 3'd2;
  localparam logic [2:0] MBUS_EIC_ACK      = 3'd3;
  localparam logic [2:0] MBUS_EIC_RELEASE  = 3'd4;

  localparam int MBUS_EIC_TO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = MBUS_EIC_IDLE,
    ST_WAIT_BUS = MBUS_EIC_WAIT_BUS,
    ST_ASSERT   = MBUS_EIC_ASSERT,
    ST_ACK      = MBUS_EIC_ACK,
    ST_RELEASE  = MBUS_EIC_RELEASE
  } eic_state_e;

  // (a + b) mod n for a < n and b < n; avoids a general divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mbus_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module mbus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only the second one is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mbus_ext_int_ctrl.sv
// Round-robin arbiter and request sequencer in front of the MBus
// external-interrupt generator. Optional watchdog is built when the
// macro MBUS_INT_TIMEOUT_EN is defined; otherwise TIMEOUT_ERR is 0.
module mbus_ext_int_ctrl
  import mbus_ext_int_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [NUM_REQ-1:0] INT_REQ,
  output logic [NUM_REQ-1:0] INT_ACK,
  output logic [ID_W-1:0]    GNT_ID,
  output logic               GNT_VALID,
  input  logic               BUS_BUSYn,
  input  logic               CLR_EXT_INT,
  output logic               REQ_INT,
  output logic               TIMEOUT_ERR
);

  logic bbn_s;
  logic clr_s;

  mbus_sync2 u_sync_bbn (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (BUS_BUSYn),
    .q     (bbn_s)
  );

  mbus_sync2 u_sync_clr (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (CLR_EXT_INT),
    .q     (clr_s)
  );

  eic_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               req_int_q, req_int_d;
  logic [NUM_REQ-1:0] int_ack_q, int_ack_d;
  logic               timeout_err_q, timeout_err_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    cand_idx;
  logic [ID_W-1:0]    next_ptr;

`ifdef MBUS_INT_TIMEOUT_EN
  localparam logic [MBUS_EIC_TO_W-1:0] TO_LIMIT = MBUS_EIC_TO_W'(TIMEOUT_CYCLES - 1);
  logic [MBUS_EIC_TO_W-1:0] wd_cnt_q, wd_cnt_d;
`else
  // Parameter kept for interface compatibility; no watchdog in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(MBUS_EIC_TO_W'(TIMEOUT_CYCLES));
`endif

  // Round-robin pick: scan offsets from high to low so the smallest offset
  // from rr_ptr (first set bit at or above it, wrapping) is the final winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_idx = ID_W'(wrap_add(int'(rr_ptr_q), i, NUM_REQ));
      if (INT_REQ[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign next_ptr = ID_W'(wrap_add(int'(gnt_id_q), 1, NUM_REQ));

  // Next-state and registered-output logic for the grant sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_id_d      = gnt_id_q;
    req_int_d     = req_int_q;
    int_ack_d     = '0;
    timeout_err_d = 1'b0;
`ifdef MBUS_INT_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_id_d = pick_idx;
          state_d  = ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: begin
        // Withdrawal beats a simultaneous bus-idle indication.
        if (!INT_REQ[gnt_id_q]) begin
          state_d = ST_IDLE;
        end else if (bbn_s) begin
          state_d   = ST_ASSERT;
          req_int_d = 1'b1;
`ifdef MBUS_INT_TIMEOUT_EN
          wd_cnt_d  = '0;
`endif
        end
      end
      ST_ASSERT: begin
        // Committed: INT_REQ is no longer looked at. A clear wins over expiry.
        if (clr_s) begin
          state_d   = ST_ACK;
          req_int_d = 1'b0;
          int_ack_d = NUM_REQ'(1) << gnt_id_q;
        end
`ifdef MBUS_INT_TIMEOUT_EN
        else if (wd_cnt_q == TO_LIMIT) begin
          state_d       = ST_RELEASE;
          req_int_d     = 1'b0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      ST_ACK: begin
        rr_ptr_d = next_ptr;
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Let the clear drop so it is not credited to the next grant.
        if (!clr_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        req_int_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops REQ_INT immediately.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      gnt_id_q      <= '0;
      req_int_q     <= 1'b0;
      int_ack_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_id_q      <= gnt_id_d;
      req_int_q     <= req_int_d;
      int_ack_q     <= int_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef MBUS_INT_TIMEOUT_EN
  // Watchdog counter, only advanced while the request is asserted.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign INT_ACK     = int_ack_q;
  assign GNT_ID      = gnt_id_q;
  assign GNT_VALID   = (state_q != ST_IDLE);
  assign REQ_INT     = req_int_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule
